// File: rtl/scs8hd_a2111oi_bist.sv
// Self-test sequencer for the a2111oi AOI cell: sweeps all 32 input vectors, samples Y after a
// settle time and counts mismatches. Define SC_BIST_MISR_EN to add the 8-bit response MISR on SIG.
module scs8hd_a2111oi_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             Y_IN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             C1,
  output logic             D1,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
`ifdef SC_BIST_MISR_EN
  output logic [7:0]       SIG,
`endif
  output logic [ERR_W-1:0] ERRCNT
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [4:0]       vec_q, vec_d;
  logic [4:0]       stim_q, stim_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [ERR_W-1:0] errcnt_q, errcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             exp_y;
  logic             mismatch;
`ifdef SC_BIST_MISR_EN
  logic [7:0]       sig_q, sig_d;
`endif

  assign exp_y = ~((vec_q[4] & vec_q[3]) | vec_q[2] | vec_q[1] | vec_q[0]);

  // An X/Z on Y_IN must register as a failure in simulation.
`ifdef SYNTHESIS
  assign mismatch = (Y_IN != exp_y);
`else
  assign mismatch = (Y_IN !== exp_y);
`endif

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    stim_d   = stim_q;
    scnt_d   = scnt_q;
    errcnt_d = errcnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
`ifdef SC_BIST_MISR_EN
    sig_d    = sig_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d  = StRun;
          vec_d    = 5'd0;
          stim_d   = 5'd0;
          scnt_d   = 4'd0;
          errcnt_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
`ifdef SC_BIST_MISR_EN
          sig_d    = 8'hFF;
`endif
        end
      end
      StRun: begin
        if (scnt_q != SettleLast) begin
          scnt_d = scnt_q + 4'd1;
        end else begin
          scnt_d = 4'd0;
          if (mismatch && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + ERR_W'(1);
          end
`ifdef SC_BIST_MISR_EN
          sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ Y_IN};
`endif
          if (vec_q == 5'd31) begin
            state_d = StDone;
            stim_d  = 5'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (errcnt_d == '0);
          end else begin
            vec_d  = vec_q + 5'd1;
            stim_d = vec_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      vec_q    <= 5'd0;
      stim_q   <= 5'd0;
      scnt_q   <= 4'd0;
      errcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef SC_BIST_MISR_EN
      sig_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      stim_q   <= stim_d;
      scnt_q   <= scnt_d;
      errcnt_q <= errcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
`ifdef SC_BIST_MISR_EN
      sig_q    <= sig_d;
`endif
    end
  end

  assign {A1, A2, B1, C1, D1} = stim_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign PASS   = pass_q;
  assign ERRCNT = errcnt_q;
`ifdef SC_BIST_MISR_EN
  assign SIG    = sig_q;
`endif

endmodule
